// File: rtl/if_id_skid_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : if_id_skid_buffer_pkg
// Brief    : Shared state encoding, NOP word and default widths for the
//            IF/ID pipeline register.
// Revision : 1.0
// ============================================================================
package if_id_skid_buffer_pkg;

    localparam int c_DEF_INSTR_W = 32;
    localparam int c_DEF_PC_W    = 32;

    // sll $0,$0,0 encodes as all zeros
    localparam logic [31:0] c_MIPS_NOP = 32'h0000_0000;

    // The state value doubles as the occupancy count
    localparam logic [1:0] c_ST_EMPTY = 2'd0;
    localparam logic [1:0] c_ST_ONE   = 2'd1;
    localparam logic [1:0] c_ST_TWO   = 2'd2;

endpackage
`default_nettype wire

// File: rtl/if_id_skid_buffer_skid_entry_reg.sv
`default_nettype none
// ============================================================================
// Module   : skid_entry_reg
// Brief    : Load-enabled {instr, pc4} register, async reset to {NOP, 0}.
// Revision : 1.0
// ============================================================================
module skid_entry_reg #(
    parameter int                   INSTR_W  = 32,
    parameter int                   PC_W     = 32,
    parameter logic [INSTR_W-1:0]   NOP_WORD = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic [PC_W-1:0]    i_pc4,
    output logic [INSTR_W-1:0] o_instr,
    output logic [PC_W-1:0]    o_pc4
);

    logic [INSTR_W-1:0] r_instr;
    logic [PC_W-1:0]    r_pc4;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instr <= NOP_WORD;
            r_pc4   <= '0;
        end else if (i_load) begin
            r_instr <= i_instr;
            r_pc4   <= i_pc4;
        end
    end

    assign o_instr = r_instr;
    assign o_pc4   = r_pc4;

endmodule
`default_nettype wire

// File: rtl/if_id_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module   : if_id_skid_buffer
// Brief    : Two-entry elastic IF/ID register with valid/ready and flush.
// Revision : 1.0
// ============================================================================
module if_id_skid_buffer
    import if_id_skid_buffer_pkg::*;
#(
    parameter int                 INSTR_W  = c_DEF_INSTR_W,
    parameter int                 PC_W     = c_DEF_PC_W,
    parameter logic [INSTR_W-1:0] NOP_WORD = c_MIPS_NOP
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc4,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc4,
    output logic [1:0]         count
);

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               w_push;
    logic               w_pop;
    logic               w_head_load;
    logic [INSTR_W-1:0] w_head_instr;
    logic [PC_W-1:0]    w_head_pc4;
    logic               w_skid_load;
    logic [INSTR_W-1:0] w_skid_instr;
    logic [PC_W-1:0]    w_skid_pc4;

    // in_ready depends on registered state only, never on out_ready
    assign in_ready  = !rst && (r_state != c_ST_TWO);
    assign out_valid = (r_state != c_ST_EMPTY);
    assign count     = r_state;
    assign w_push    = in_valid && in_ready && !flush;
    assign w_pop     = out_valid && out_ready;

    // Every transition into EMPTY reloads the head with a bubble
    always_comb begin
        w_state_nxt  = r_state;
        w_head_load  = 1'b0;
        w_head_instr = in_instr;
        w_head_pc4   = in_pc4;
        w_skid_load  = 1'b0;
        if (flush) begin
            w_state_nxt  = c_ST_EMPTY;
            w_head_load  = 1'b1;
            w_head_instr = NOP_WORD;
            w_head_pc4   = '0;
        end else begin
            case (r_state)
                c_ST_EMPTY: begin
                    if (w_push) begin
                        w_state_nxt = c_ST_ONE;
                        w_head_load = 1'b1;
                    end
                end
                c_ST_ONE: begin
                    if (w_push && w_pop) begin
                        w_head_load = 1'b1;
                    end else if (w_push) begin
                        w_state_nxt = c_ST_TWO;
                        w_skid_load = 1'b1;
                    end else if (w_pop) begin
                        w_state_nxt  = c_ST_EMPTY;
                        w_head_load  = 1'b1;
                        w_head_instr = NOP_WORD;
                        w_head_pc4   = '0;
                    end
                end
                c_ST_TWO: begin
                    if (w_pop) begin
                        w_state_nxt  = c_ST_ONE;
                        w_head_load  = 1'b1;
                        w_head_instr = w_skid_instr;
                        w_head_pc4   = w_skid_pc4;
                    end
                end
                default: begin
                    w_state_nxt  = c_ST_EMPTY;
                    w_head_load  = 1'b1;
                    w_head_instr = NOP_WORD;
                    w_head_pc4   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    skid_entry_reg #(
        .INSTR_W  (INSTR_W),
        .PC_W     (PC_W),
        .NOP_WORD (NOP_WORD)
    ) u_head (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_head_load),
        .i_instr (w_head_instr),
        .i_pc4   (w_head_pc4),
        .o_instr (out_instr),
        .o_pc4   (out_pc4)
    );

    skid_entry_reg #(
        .INSTR_W  (INSTR_W),
        .PC_W     (PC_W),
        .NOP_WORD (NOP_WORD)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_skid_load),
        .i_instr (in_instr),
        .i_pc4   (in_pc4),
        .o_instr (w_skid_instr),
        .o_pc4   (w_skid_pc4)
    );

endmodule
`default_nettype wire
